// File: rtl/quad_input_filter_if.sv
// Bus bundle for quad_input_filter: raw encoder pins and filter length in,
// filtered levels and error status out.
interface quad_input_filter_if #(
  parameter int NCH    = 4,
  parameter int FILT_W = 4
);
  logic [NCH-1:0]    quadA_in;
  logic [NCH-1:0]    quadB_in;
  logic [NCH-1:0]    quadZ_in;
  logic [FILT_W-1:0] filt_len;
  logic [NCH-1:0]    err_clr;
  logic [NCH-1:0]    quadA;
  logic [NCH-1:0]    quadB;
  logic [NCH-1:0]    quadZ;
  logic [NCH-1:0]    err;
  logic [8*NCH-1:0]  err_count;

  modport master (
    output quadA_in, quadB_in, quadZ_in, filt_len, err_clr,
    input  quadA, quadB, quadZ, err, err_count
  );

  modport slave (
    input  quadA_in, quadB_in, quadZ_in, filt_len, err_clr,
    output quadA, quadB, quadZ, err, err_count
  );
endinterface

// File: rtl/quad_input_filter.sv
// quad_input_filter: per-pin 2-flop synchronizer plus stability-window
// glitch filter for NCH A/B/Z encoder channels, with sticky illegal
// quadrature transition flags. Optional feature macro QUAD_ERR_COUNT_EN
// adds per-channel 8-bit saturating illegal-event counters; without it
// err_count is tied to zero.

// One filtered pin: synchronizer, stability counter, filtered level.
module quad_filt_bit #(
  parameter int FILT_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              run,
  input  logic [FILT_W-1:0] filt_len,
  input  logic              din,
  output logic              sync,
  output logic              dout
);
  logic              s1, s2;
  logic [FILT_W-1:0] cnt;

  assign sync = s2;

  // Synchronize, then accept a new level only after filt_len+1 agreeing samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      cnt  <= '0;
      dout <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (load) begin
        dout <= s2;
        cnt  <= '0;
      end else if (run) begin
        if (s2 == dout) begin
          cnt <= '0;
        end else if (cnt >= filt_len) begin
          dout <= s2;
          cnt  <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

module quad_input_filter #(
  parameter int NCH    = 4,
  parameter int FILT_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  quad_input_filter_if.slave  bus
);
  typedef enum logic [1:0] {INIT0, INIT1, LOAD, RUN} state_t;

  state_t state, state_nxt;
  logic   load, run;

  logic [3*NCH-1:0] raw, sync, filt;
  logic [NCH-1:0]   a_d, b_d, illegal;
  logic             unused_sync_z;

  // Startup sequencer register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= INIT0;
    else       state <= state_nxt;
  end

  // Startup sequencer next state; RUN is absorbing
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    run       = 1'b0;
    case (state)
      INIT0:   state_nxt = INIT1;
      INIT1:   state_nxt = LOAD;
      LOAD:    begin state_nxt = RUN; load = 1'b1; end
      RUN:     run = 1'b1;
      default: state_nxt = INIT0;
    endcase
  end

  assign raw = {bus.quadZ_in, bus.quadB_in, bus.quadA_in};

  quad_filt_bit #(.FILT_W(FILT_W)) u_bit [3*NCH-1:0] (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .run      (run),
    .filt_len (bus.filt_len),
    .din      (raw),
    .sync     (sync),
    .dout     (filt)
  );

  assign bus.quadA   = filt[NCH-1:0];
  assign bus.quadB   = filt[2*NCH-1:NCH];
  assign bus.quadZ   = filt[3*NCH-1:2*NCH];
  // Z is filtered but never checked for illegal transitions
  assign unused_sync_z = ^sync[3*NCH-1:2*NCH];

  assign illegal = {NCH{run}} & (bus.quadA ^ a_d) & (bus.quadB ^ b_d);

  // Delayed filtered A/B; seeded from the synchronizer on LOAD so the
  // initial encoder state never looks like a transition
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_d <= '0;
      b_d <= '0;
    end else if (load) begin
      a_d <= sync[NCH-1:0];
      b_d <= sync[2*NCH-1:NCH];
    end else if (run) begin
      a_d <= bus.quadA;
      b_d <= bus.quadB;
    end
  end

  // Sticky error flags; a new illegal event beats a same-edge clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) bus.err <= '0;
    else       bus.err <= illegal | (bus.err & ~bus.err_clr);
  end

`ifdef QUAD_ERR_COUNT_EN
  for (genvar n = 0; n < NCH; n++) begin : g_cnt
    logic [7:0] ecnt;

    // Saturating event counter; clear with a same-edge event lands on 1
    always_ff @(posedge clk or posedge reset) begin
      if (reset)                             ecnt <= 8'd0;
      else if (bus.err_clr[n])               ecnt <= illegal[n] ? 8'd1 : 8'd0;
      else if (illegal[n] && ecnt != 8'hFF)  ecnt <= ecnt + 8'd1;
    end

    assign bus.err_count[8*n +: 8] = ecnt;
  end
`else
  assign bus.err_count = '0;
`endif
endmodule

// File: tb/tb_quad_input_filter.sv
// Directed bench for quad_input_filter: startup load, glitch rejection,
// latency, illegal-transition flags, live filt_len change, mid-run reset.
module tb_quad_input_filter;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  quad_input_filter_if #(.NCH(4), .FILT_W(4)) bus ();

  quad_input_filter #(.NCH(4), .FILT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance past one rising edge; inputs set and outputs read here sit mid-cycle
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset        = 1'b1;
    bus.quadA_in = 4'b0001;
    bus.quadB_in = 4'b0001;
    bus.quadZ_in = 4'b0000;
    bus.filt_len = 4'd0;
    bus.err_clr  = 4'b0000;

    // Reset state
    tick(3);
    chk("rst_quadA", {28'd0, bus.quadA}, 32'h0);
    chk("rst_quadB", {28'd0, bus.quadB}, 32'h0);
    chk("rst_err",   {28'd0, bus.err},   32'h0);
    chk("rst_cnt",   bus.err_count,      32'h0);

    // Release: filtered outputs load on the 3rd edge
    reset = 1'b0;
    tick(2);
    chk("init_a_e2", {28'd0, bus.quadA}, 32'h0);
    tick(1);
    chk("load_a_e3", {28'd0, bus.quadA}, 32'h1);
    chk("load_b_e3", {28'd0, bus.quadB}, 32'h1);
    tick(3);
    chk("load_noerr", {28'd0, bus.err}, 32'h0);

    // filt_len=3: 3-cycle glitch rejected
    bus.filt_len = 4'd3;
    bus.quadA_in[1] = 1'b1;
    tick(3);
    bus.quadA_in[1] = 1'b0;
    for (int i = 0; i < 8; i++) chk($sformatf("glitch3_%0d", i), {31'd0, bus.quadA[1]}, 32'h0);
    tick(1);
    chk("glitch3_late", {31'd0, bus.quadA[1]}, 32'h0);
    tick(6);

    // 4-cycle pulse passes, high after edges k+5..k+8
    bus.quadA_in[1] = 1'b1;
    tick(4);
    bus.quadA_in[1] = 1'b0;
    tick(1);
    chk("pulse4_k4", {31'd0, bus.quadA[1]}, 32'h0);
    for (int i = 5; i <= 8; i++) begin
      tick(1);
      chk($sformatf("pulse4_k%0d", i), {31'd0, bus.quadA[1]}, 32'h1);
    end
    tick(1);
    chk("pulse4_k9", {31'd0, bus.quadA[1]}, 32'h0);
    chk("pulse4_noerr", {31'd0, bus.err[1]}, 32'h0);

    // filt_len=0: A and B together on ch2
    bus.filt_len = 4'd0;
    tick(2);
    bus.quadA_in[2] = 1'b1;
    bus.quadB_in[2] = 1'b1;
    tick(2);
    chk("ill_k1_a", {31'd0, bus.quadA[2]}, 32'h0);
    tick(1);
    chk("ill_k2_a", {31'd0, bus.quadA[2]}, 32'h1);
    chk("ill_k2_b", {31'd0, bus.quadB[2]}, 32'h1);
    chk("ill_k2_err", {31'd0, bus.err[2]}, 32'h0);
    tick(1);
    chk("ill_k3_err", {31'd0, bus.err[2]}, 32'h1);
    tick(2);
    chk("ill_sticky", {31'd0, bus.err[2]}, 32'h1);
`ifdef QUAD_ERR_COUNT_EN
    chk("ill_cnt1", {24'd0, bus.err_count[23:16]}, 32'd1);
`endif
    bus.err_clr[2] = 1'b1;
    tick(1);
    bus.err_clr[2] = 1'b0;
    chk("clr_err", {31'd0, bus.err[2]}, 32'h0);
`ifdef QUAD_ERR_COUNT_EN
    chk("clr_cnt", {24'd0, bus.err_count[23:16]}, 32'd0);
`endif

    // Clear on the same edge as a new illegal event: set wins
    bus.quadA_in[2] = 1'b0;
    bus.quadB_in[2] = 1'b0;
    tick(3);
    chk("set_clr_pre", {31'd0, bus.err[2]}, 32'h0);
    bus.err_clr[2] = 1'b1;
    tick(1);
    bus.err_clr[2] = 1'b0;
    chk("set_wins", {31'd0, bus.err[2]}, 32'h1);
`ifdef QUAD_ERR_COUNT_EN
    chk("set_clr_cnt", {24'd0, bus.err_count[23:16]}, 32'd1);
`else
    chk("cnt_tied0_a", bus.err_count, 32'h0);
`endif

    // Lowering filt_len mid-count takes effect on the next edge
    bus.filt_len = 4'd15;
    bus.quadB_in[0] = 1'b0;
    tick(12);
    chk("flen_k11", {31'd0, bus.quadB[0]}, 32'h1);
    bus.filt_len = 4'd2;
    tick(1);
    chk("flen_k12", {31'd0, bus.quadB[0]}, 32'h0);
    chk("flen_noerr", {31'd0, bus.err[0]}, 32'h0);

    // 300 illegal events on ch3
    bus.filt_len = 4'd0;
    for (int i = 0; i < 300; i++) begin
      bus.quadA_in[3] = ~bus.quadA_in[3];
      bus.quadB_in[3] = ~bus.quadB_in[3];
      tick(1);
    end
    tick(5);
    chk("sat_err", {31'd0, bus.err[3]}, 32'h1);
`ifdef QUAD_ERR_COUNT_EN
    chk("sat_cnt", {24'd0, bus.err_count[31:24]}, 32'd255);
`else
    chk("cnt_tied0_b", bus.err_count, 32'h0);
`endif
    bus.err_clr[3] = 1'b1;
    tick(1);
    bus.err_clr[3] = 1'b0;
    chk("sat_clr_err", {31'd0, bus.err[3]}, 32'h0);
`ifdef QUAD_ERR_COUNT_EN
    chk("sat_clr_cnt", {24'd0, bus.err_count[31:24]}, 32'd0);
`endif

    // Reset while quadB[0] is mid-filter; err[2] is still set going in
    bus.filt_len = 4'd15;
    bus.quadB_in[0] = 1'b1;
    tick(5);
    chk("pre_rst_b", {31'd0, bus.quadB[0]}, 32'h0);
    chk("pre_rst_err", {28'd0, bus.err}, 32'h4);
    #2 reset = 1'b1;
    #1;
    chk("async_a",   {28'd0, bus.quadA}, 32'h0);
    chk("async_b",   {28'd0, bus.quadB}, 32'h0);
    chk("async_err", {28'd0, bus.err},   32'h0);
    chk("async_cnt", bus.err_count,      32'h0);
    tick(2);
    reset = 1'b0;
    tick(2);
    chk("reload_e2", {28'd0, bus.quadB}, 32'h0);
    tick(1);
    chk("reload_a", {28'd0, bus.quadA}, 32'h1);
    chk("reload_b", {28'd0, bus.quadB}, 32'h1);
    tick(2);
    chk("reload_noerr", {28'd0, bus.err}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
